// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH-channel flip-flop bank that behaves as D, T, JK or SR
// flip-flops (selected by mode), built around a shared toggle core q <= q ^ t.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   en              update enable for all channels
//   mode            00 D, 01 T, 10 JK, 11 SR
//   a, b            per-channel D/T/J/S and K/R inputs
//   load, load_val  parallel load strobe and data (overrides en)
//   err_clr         clears sr_err and err_cnt
//   q, q_n          channel state and its inverse (q_n is combinational)
//   toggled         bits that changed on the most recent edge
//   sr_err, err_cnt sticky illegal-SR flag and saturating event counter
module multi_mode_ff_bank #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned SR_POLICY = 0,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [1:0]           mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_val,
   input  logic                 err_clr,
   output logic [WIDTH-1:0]     q,
   output logic [WIDTH-1:0]     q_n,
   output logic [WIDTH-1:0]     toggled,
   output logic                 sr_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [1:0] MODE_D  = 2'b00;
   localparam logic [1:0] MODE_T  = 2'b01;
   localparam logic [1:0] MODE_JK = 2'b10;
   localparam logic [1:0] MODE_SR = 2'b11;

   localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

   logic [WIDTH-1:0] jk_t;
   logic [WIDTH-1:0] both;
   logic [WIDTH-1:0] pol_t;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] q_next;
   logic             illegal;

   // Per-bit toggle vector for the selected mode
   always_comb begin
      jk_t  = (a & ~q) | (b & q);
      both  = a & b;
      pol_t = '0;
      if (SR_POLICY == 1) begin
         pol_t = ~q;
      end else if (SR_POLICY == 2) begin
         pol_t = q;
      end
      t = '0;
      case (mode)
         MODE_D:  t = a ^ q;
         MODE_T:  t = a;
         MODE_JK: t = jk_t;
         MODE_SR: t = (jk_t & ~both) | (pol_t & both);
         default: t = '0;
      endcase
   end

   // Next state with load > en priority; reset is handled in the register
   always_comb begin
      q_next = q;
      if (load) begin
         q_next = load_val;
      end else if (en) begin
         q_next = q ^ t;
      end
   end

   // One illegal event per cycle, regardless of how many bits have S=R=1
   assign illegal = (mode == MODE_SR) && en && !load && (|both);

   // State, change flags and error tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         q       <= '0;
         toggled <= '0;
         sr_err  <= 1'b0;
         err_cnt <= '0;
      end else begin
         q       <= q_next;
         toggled <= q_next ^ q;
         if (illegal) begin
            sr_err <= 1'b1;
            if (err_clr) begin
               err_cnt <= CNT_ONE;
            end else if (err_cnt != CNT_MAX) begin
               err_cnt <= err_cnt + CNT_ONE;
            end
         end else if (err_clr) begin
            sr_err  <= 1'b0;
            err_cnt <= '0;
         end
      end
   end

   assign q_n = ~q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed testbench for multi_mode_ff_bank: three instances share the stimulus,
// one per SR_POLICY (hold, set-dominant, reset-dominant).
module tb_multi_mode_ff_bank;

   localparam int unsigned WIDTH     = 8;
   localparam int unsigned ERR_CNT_W = 4;

   logic                 clk;
   logic                 reset;
   logic                 en;
   logic [1:0]           mode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 load;
   logic [WIDTH-1:0]     load_val;
   logic                 err_clr;

   logic [WIDTH-1:0]     q0, q1, q2, qn0, qn1, qn2, tg0, tg1, tg2;
   logic                 se0, se1, se2;
   logic [ERR_CNT_W-1:0] ec0, ec1, ec2;

   int n_checks = 0;
   int n_fail   = 0;

   multi_mode_ff_bank #(.WIDTH(WIDTH), .SR_POLICY(0), .ERR_CNT_W(ERR_CNT_W)) u_hold (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
      .load(load), .load_val(load_val), .err_clr(err_clr),
      .q(q0), .q_n(qn0), .toggled(tg0), .sr_err(se0), .err_cnt(ec0));

   multi_mode_ff_bank #(.WIDTH(WIDTH), .SR_POLICY(1), .ERR_CNT_W(ERR_CNT_W)) u_set (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
      .load(load), .load_val(load_val), .err_clr(err_clr),
      .q(q1), .q_n(qn1), .toggled(tg1), .sr_err(se1), .err_cnt(ec1));

   multi_mode_ff_bank #(.WIDTH(WIDTH), .SR_POLICY(2), .ERR_CNT_W(ERR_CNT_W)) u_rst (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
      .load(load), .load_val(load_val), .err_clr(err_clr),
      .q(q2), .q_n(qn2), .toggled(tg2), .sr_err(se2), .err_cnt(ec2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle before sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1; en = 1'b0; mode = 2'b00; a = '0; b = '0;
      load = 1'b0; load_val = '0; err_clr = 1'b0;

      // Reset
      step();
      check("rst_q",   32'(q0),  32'h00);
      check("rst_qn",  32'(qn0), 32'hFF);
      check("rst_tg",  32'(tg0), 32'h00);
      check("rst_err", 32'(se0), 32'h0);
      check("rst_cnt", 32'(ec0), 32'h0);

      // D mode
      reset = 1'b0; en = 1'b1; mode = 2'b00; a = 8'hA5;
      step();
      check("d_q",  32'(q0),  32'hA5);
      check("d_qn", 32'(qn0), 32'h5A);
      check("d_tg", 32'(tg0), 32'hA5);

      // Load 0x0F, then T mode
      load = 1'b1; load_val = 8'h0F;
      step();
      check("ld0f_q",  32'(q0),  32'h0F);
      check("ld0f_tg", 32'(tg0), 32'hAA);
      load = 1'b0; mode = 2'b01; a = 8'hFF;
      step();
      check("t1_q",  32'(q0),  32'hF0);
      check("t1_tg", 32'(tg0), 32'hFF);
      step();
      check("t2_q",  32'(q0),  32'h0F);
      check("t2_tg", 32'(tg0), 32'hFF);
      en = 1'b0;
      step();
      check("t_hold_q",  32'(q0),  32'h0F);
      check("t_hold_tg", 32'(tg0), 32'h00);

      // JK mode from 0x00
      load = 1'b1; load_val = 8'h00;
      step();
      load = 1'b0; en = 1'b1; mode = 2'b10; a = 8'h03; b = 8'h0C;
      step();
      check("jk1_q", 32'(q0), 32'h03);
      a = 8'h00; b = 8'h01;
      step();
      check("jk2_q",  32'(q0),  32'h02);
      check("jk2_tg", 32'(tg0), 32'h01);

      // SR mode (legal) from 0x00
      load = 1'b1; load_val = 8'h00;
      step();
      load = 1'b0; mode = 2'b11; a = 8'h03; b = 8'h0C;
      step();
      check("sr1_q", 32'(q0), 32'h03);
      a = 8'h00; b = 8'h01;
      step();
      check("sr2_q",   32'(q0), 32'h02);
      check("sr2_cnt", 32'(ec0), 32'h0);

      // Load 0x0F while S=R=1 present: load masks the event
      load = 1'b1; load_val = 8'h0F; a = 8'hFF; b = 8'hFF;
      step();
      check("ld_ill_q",   32'(q0),  32'h0F);
      check("ld_ill_cnt", 32'(ec0), 32'h0);
      check("ld_ill_err", 32'(se0), 32'h0);

      // Illegal SR under each policy
      load = 1'b0;
      step();
      check("ill_hold_q", 32'(q0),  32'h0F);
      check("ill_set_q",  32'(q1),  32'hFF);
      check("ill_rst_q",  32'(q2),  32'h00);
      check("ill_err0",   32'(se0), 32'h1);
      check("ill_err1",   32'(se1), 32'h1);
      check("ill_err2",   32'(se2), 32'h1);
      check("ill_cnt0",   32'(ec0), 32'h1);
      check("ill_cnt1",   32'(ec1), 32'h1);
      check("ill_cnt2",   32'(ec2), 32'h1);

      // Saturation: 15 events reach max, 20 stay there
      for (int i = 0; i < 14; i++) step();
      check("sat15_cnt", 32'(ec0), 32'hF);
      for (int i = 0; i < 5; i++) step();
      check("sat20_cnt0", 32'(ec0), 32'hF);
      check("sat20_cnt1", 32'(ec1), 32'hF);
      check("sat20_cnt2", 32'(ec2), 32'hF);
      check("sat_set_q",  32'(q1),  32'hFF);
      check("sat_set_tg", 32'(tg1), 32'h00);
      check("sat_rst_q",  32'(q2),  32'h00);

      // Clear coincident with event: event wins
      err_clr = 1'b1;
      step();
      check("clr_ev_cnt", 32'(ec0), 32'h1);
      check("clr_ev_err", 32'(se0), 32'h1);
      // Clear with en=0: S=R=1 not counted
      en = 1'b0;
      step();
      check("clr_cnt", 32'(ec0), 32'h0);
      check("clr_err", 32'(se0), 32'h0);
      err_clr = 1'b0;
      step();
      check("en0_ill_cnt", 32'(ec0), 32'h0);

      // Load overrides enabled T mode
      en = 1'b1; mode = 2'b01; a = 8'hFF; b = 8'h00; load = 1'b1; load_val = 8'h3C;
      step();
      check("ld3c_q0", 32'(q0), 32'h3C);
      check("ld3c_q1", 32'(q1), 32'h3C);

      // One event so counters are nonzero, then reset with load
      load = 1'b0; mode = 2'b11; a = 8'hFF; b = 8'hFF;
      step();
      check("pre_rst_cnt", 32'(ec0), 32'h1);
      reset = 1'b1; load = 1'b1; load_val = 8'hAA;
      step();
      check("rst_ld_q",   32'(q1),  32'h00);
      check("rst_ld_qn",  32'(qn1), 32'hFF);
      check("rst_ld_tg",  32'(tg1), 32'h00);
      check("rst_ld_cnt", 32'(ec1), 32'h0);
      check("rst_ld_err", 32'(se1), 32'h0);

      // First post-reset update
      reset = 1'b0; load = 1'b0; mode = 2'b00; a = 8'h55; b = 8'h00;
      step();
      check("post_rst_q",  32'(q0),  32'h55);
      check("post_rst_tg", 32'(tg0), 32'h55);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_mode_ff_bank.md
MULTI_MODE_FF_BANK -- requirements
Module: multi_mode_ff_bank

Interface
REQ-001 The block SHALL be clocked by clk, with reset being reset, synchronous, active-high.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 8, number of independent flip-flop channels (1..64).
- SR_POLICY, 0, S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant; values 3 and above behave as 0.
- ERR_CNT_W, 8, width of the illegal-event counter (2..16).

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- en, in, 1, update enable for all channels.
- mode, in, 2, 00 D, 01 T, 10 JK, 11 SR; applies to all channels.
- a, in, WIDTH, per-channel D / T / J / S input.
- b, in, WIDTH, per-channel K / R input; ignored in D and T modes.
- load, in, 1, parallel load strobe.
- load_val, in, WIDTH, parallel load data.
- err_clr, in, 1, clears sr_err and err_cnt.
- q, out, WIDTH, channel state.
- q_n, out, WIDTH, bitwise inverse of q.
- toggled, out, WIDTH, per-channel flag: bit changed on the most recent clock edge.
- sr_err, out, 1, sticky illegal-input flag.
- err_cnt, out, ERR_CNT_W, count of cycles with an illegal input.

Function
REQ-004 Every channel SHALL be implemented as a toggle core: q_next = q XOR t, where t is the per-channel toggle vector derived from mode, a, b and q.
REQ-005 Per-bit t derivation SHALL be:
- D: t = a XOR q.
- T: t = a.
- JK: t = (a AND NOT q) OR (b AND q).
- SR with a != b: t = (a AND NOT q) OR (b AND q).
- SR with a = b = 1: t per SR_POLICY (hold: 0; set-dominant: NOT q; reset-dominant: q).

REQ-006 mode SHALL be sampled combinationally each cycle; a mode change takes effect on the same clock edge with no pipeline delay.
REQ-007 Update priority per edge SHALL be reset > load > en; with en=0 and load=0, q holds.
REQ-008 load=1 SHALL set q <= load_val regardless of en and mode, with latency 1 clock.
REQ-009 q_n SHALL equal NOT q combinationally at all times, including during reset.
REQ-010 toggled SHALL be registered as q_next XOR q on every edge, so that it is valid in the same cycle the new q appears. It SHALL be 0 on any edge where q does not change.
REQ-011 An illegal event SHALL be a cycle with mode=11, en=1, load=0, reset=0 and (a AND b) != 0.
- One event SHALL be counted per cycle, regardless of how many bits are illegal.
- Events SHALL NOT be counted when en=0 or load=1.

REQ-012 On an illegal event, sr_err SHALL be set to 1 and err_cnt SHALL increment by 1, saturating at 2^ERR_CNT_W-1 with no wrap-around.
REQ-013 err_clr=1 without an illegal event SHALL set sr_err <= 0 and err_cnt <= 0.
REQ-014 err_clr=1 coincident with an illegal event SHALL set sr_err <= 1 and err_cnt <= 1 (event wins after clear).
REQ-015 sr_err and err_cnt SHALL be independent of q; the SR_POLICY action on q SHALL still be applied on illegal cycles.
REQ-016 All outputs SHALL be driven directly by registers, except q_n, which is a single inversion of q.

Reset
REQ-017 reset=1 SHALL, on the next clk edge, set q=0, toggled=0, sr_err=0 and err_cnt=0 (q_n therefore all 1s).
REQ-018 reset SHALL override load, en, err_clr and any illegal event in the same cycle; no event is counted while reset=1.
REQ-019 Reset asserted mid-operation SHALL discard in-flight updates; the first post-reset update occurs on the first edge with reset=0.

Verification
REQ-020 The bench SHALL cover the following directed scenarios (WIDTH=8, ERR_CNT_W=4 unless stated):
- D mode: reset, en=1, a=0xA5 for 1 clk -> q=0xA5, q_n=0x5A, toggled=0xA5.
- T mode: from q=0x0F, a=0xFF for 2 clks -> q=0xF0 then 0x0F, toggled=0xFF both cycles; en=0 -> q holds, toggled=0x00.
- JK/SR mode: from q=0x00, a=0x03, b=0x0C -> q=0x03; then a=0x00, b=0x01 -> q=0x02.
- SR illegal with SR_POLICY set to each of 0, 1, 2: q=0x0F, a=b=0xFF -> q=0x0F, 0xFF and 0x00 respectively, sr_err=1, err_cnt=1. Repeat 20 cycles -> err_cnt saturates at 15.
- err_clr held with an illegal event -> err_cnt=1, sr_err=1; err_clr with no event -> err_cnt=0, sr_err=0.
- load=1, load_val=0x3C with en=1, mode=T, a=0xFF -> q=0x3C. Reset asserted with load in the same cycle -> q=0x00, counters 0.
